// File: rtl/a2_bus_dout_arbiter.sv
// a2_bus_dout_arbiter
//   Per-bus-cycle arbiter for the Apple II data-bus output path. Once per
//   6502 cycle it picks one slot-card read source (lowest index wins), drives
//   its byte onto the IOBUF inside the phi0 window, and counts cycles where
//   more than one source asked to drive.
//
//   Optional feature: define A2_DOUT_ARB_WATCHDOG_EN to add a DRIVE-state
//   watchdog that releases the bus after MAX_DRIVE_CYCLES without a
//   phi1_posedge and sets the sticky timeout_o flag. Without it timeout_o
//   is tied 0 and DRIVE waits indefinitely.
//
// Ports:
//   clk_logic         logic clock
//   system_reset_n    async active-low reset
//   phi1_posedge      strobe, phi0 falling (end of bus cycle)
//   phi1_negedge      strobe, phi0 rising (start of data phase)
//   rw_n_i            Apple II R/W, 1 = read
//   req_i             per-source read enables
//   data_i            per-source bytes, source k at [8k+7:8k]
//   data_out_o        byte to IOBUF
//   data_out_en_o     IOBUF drive enable / bus direction
//   grant_o           one-hot owner, zero when not driving
//   conflict_o        one-cycle pulse on multi-source evaluation
//   conflict_count_o  saturating conflict counter
//   timeout_o         sticky watchdog flag
//
// state | meaning
// IDLE  | bus not driven, waiting for phi1_negedge
// GUARD | counting guard interval before grant evaluation
// DRIVE | granted source driving the bus
// HOLD  | phi0 has fallen, bus held for the hold interval

module a2_bus_dout_arbiter #(
    parameter int NUM_REQ          = 4,
    parameter int GUARD_CYCLES     = 2,
    parameter int HOLD_CYCLES      = 1,
    parameter int MAX_DRIVE_CYCLES = 64
) (
    input  logic                 clk_logic,
    input  logic                 system_reset_n,
    input  logic                 phi1_posedge,
    input  logic                 phi1_negedge,
    input  logic                 rw_n_i,
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic [NUM_REQ*8-1:0] data_i,
    output logic [7:0]           data_out_o,
    output logic                 data_out_en_o,
    output logic [NUM_REQ-1:0]   grant_o,
    output logic                 conflict_o,
    output logic [15:0]          conflict_count_o,
    output logic                 timeout_o
);

    if (GUARD_CYCLES < 1 || GUARD_CYCLES > 15) begin : g_chk_guard
        $error("GUARD_CYCLES must be in 1..15");
    end
    if (HOLD_CYCLES < 0 || HOLD_CYCLES > 15) begin : g_chk_hold
        $error("HOLD_CYCLES must be in 0..15");
    end
    if (MAX_DRIVE_CYCLES < 1) begin : g_chk_max
        $error("MAX_DRIVE_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, GUARD, DRIVE, HOLD} state_t;

    localparam logic [3:0] GUARD_LOAD = 4'(GUARD_CYCLES - 1);
    localparam logic [3:0] HOLD_LOAD  = (HOLD_CYCLES > 0) ? 4'(HOLD_CYCLES - 1) : 4'd0;

    state_t               r_state;
    logic [3:0]           r_cnt;
    logic [7:0]           r_dout;
    logic                 r_en;
    logic [NUM_REQ-1:0]   r_grant;
    logic                 r_conflict;
    logic [15:0]          r_conflict_count;

    logic [NUM_REQ-1:0]   w_win_onehot;
    logic [7:0]           w_win_data;
    logic [7:0]           w_grant_data;
    logic                 w_multi;

`ifdef A2_DOUT_ARB_WATCHDOG_EN
    localparam int            WD_W    = (MAX_DRIVE_CYCLES > 1) ? $clog2(MAX_DRIVE_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(MAX_DRIVE_CYCLES - 1);
    logic [WD_W-1:0]      r_wd_cnt;
    logic                 r_timeout;
`endif

    // Descending scan so the lowest set index is the last (winning) write.
    always_comb begin
        w_win_onehot = '0;
        w_win_data   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_i[k]) begin
                w_win_onehot    = '0;
                w_win_onehot[k] = 1'b1;
                w_win_data      = data_i[8*k +: 8];
            end
        end
    end

    always_comb begin
        w_grant_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (r_grant[k]) begin
                w_grant_data = data_i[8*k +: 8];
            end
        end
    end

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign w_multi = (req_i & (req_i - NUM_REQ'(1))) != '0;

    always_ff @(posedge clk_logic or negedge system_reset_n) begin
        if (!system_reset_n) begin
            r_state          <= IDLE;
            r_cnt            <= '0;
            r_dout           <= '0;
            r_en             <= 1'b0;
            r_grant          <= '0;
            r_conflict       <= 1'b0;
            r_conflict_count <= '0;
`ifdef A2_DOUT_ARB_WATCHDOG_EN
            r_wd_cnt         <= '0;
            r_timeout        <= 1'b0;
`endif
        end else begin
            r_conflict <= 1'b0;
            // A new phi0 rise always wins, also over a coincident phi0 fall.
            if (phi1_negedge) begin
                r_state <= GUARD;
                r_cnt   <= GUARD_LOAD;
                r_en    <= 1'b0;
                r_grant <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                    end
                    GUARD: begin
                        if (r_cnt != 4'd0) begin
                            r_cnt <= r_cnt - 4'd1;
                        end else if (rw_n_i && (req_i != '0)) begin
                            r_state <= DRIVE;
                            r_en    <= 1'b1;
                            r_grant <= w_win_onehot;
                            r_dout  <= w_win_data;
                            if (w_multi) begin
                                r_conflict <= 1'b1;
                                if (r_conflict_count != 16'hFFFF) begin
                                    r_conflict_count <= r_conflict_count + 16'd1;
                                end
                            end
`ifdef A2_DOUT_ARB_WATCHDOG_EN
                            r_wd_cnt <= WD_LOAD;
`endif
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                    DRIVE: begin
                        if (!rw_n_i) begin
                            r_state <= IDLE;
                            r_en    <= 1'b0;
                            r_grant <= '0;
                        end else if (phi1_posedge) begin
                            if (HOLD_CYCLES > 0) begin
                                r_state <= HOLD;
                                r_cnt   <= HOLD_LOAD;
                            end else begin
                                r_state <= IDLE;
                                r_en    <= 1'b0;
                                r_grant <= '0;
                            end
`ifdef A2_DOUT_ARB_WATCHDOG_EN
                        end else if (r_wd_cnt == '0) begin
                            r_state   <= IDLE;
                            r_en      <= 1'b0;
                            r_grant   <= '0;
                            r_timeout <= 1'b1;
                        end else begin
                            r_wd_cnt <= r_wd_cnt - WD_W'(1);
                            r_dout   <= w_grant_data;
                        end
`else
                        end else begin
                            r_dout <= w_grant_data;
                        end
`endif
                    end
                    HOLD: begin
                        if (r_cnt != 4'd0) begin
                            r_cnt <= r_cnt - 4'd1;
                        end else begin
                            r_state <= IDLE;
                            r_en    <= 1'b0;
                            r_grant <= '0;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_en    <= 1'b0;
                        r_grant <= '0;
                    end
                endcase
            end
        end
    end

    assign data_out_o       = r_dout;
    assign data_out_en_o    = r_en;
    assign grant_o          = r_grant;
    assign conflict_o       = r_conflict;
    assign conflict_count_o = r_conflict_count;
`ifdef A2_DOUT_ARB_WATCHDOG_EN
    assign timeout_o        = r_timeout;
`else
    assign timeout_o        = 1'b0;
`endif

endmodule

// File: tb/tb_a2_bus_dout_arbiter.sv
// Bench for a2_bus_dout_arbiter: directed bus cycles plus randomized strobes,
// requests and data, checked every cycle against a timestamp-based model.

module tb_a2_bus_dout_arbiter;

    localparam int G   = 2;
    localparam int H   = 1;
    localparam int MAX = 64;

    logic        clk_logic;
    logic        system_reset_n;
    logic        phi1_posedge;
    logic        phi1_negedge;
    logic        rw_n_i;
    logic [3:0]  req_i;
    logic [31:0] data_i;
    logic [7:0]  data_out_o;
    logic        data_out_en_o;
    logic [3:0]  grant_o;
    logic        conflict_o;
    logic [15:0] conflict_count_o;
    logic        timeout_o;

    a2_bus_dout_arbiter #(
        .NUM_REQ(4), .GUARD_CYCLES(G), .HOLD_CYCLES(H), .MAX_DRIVE_CYCLES(MAX)
    ) dut (
        .clk_logic(clk_logic),
        .system_reset_n(system_reset_n),
        .phi1_posedge(phi1_posedge),
        .phi1_negedge(phi1_negedge),
        .rw_n_i(rw_n_i),
        .req_i(req_i),
        .data_i(data_i),
        .data_out_o(data_out_o),
        .data_out_en_o(data_out_en_o),
        .grant_o(grant_o),
        .conflict_o(conflict_o),
        .conflict_count_o(conflict_count_o),
        .timeout_o(timeout_o)
    );

    initial clk_logic = 1'b0;
    always #5 clk_logic = ~clk_logic;

    int n_checks = 0;
    int n_fail   = 0;
    int t        = 0;

    // Model: timestamps of the pending evaluation and the end of the hold.
    logic        m_en, m_conf, m_tmo;
    logic [3:0]  m_grant;
    logic [7:0]  m_dout;
    logic [15:0] m_count;
    bit          m_guard, m_drv;
    int          m_eval_t, m_off_t, m_start_t, m_idx;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, want %0h", tag, t, obs, exp);
        end
    endtask

    function automatic int lowest(input logic [3:0] r);
        for (int i = 0; i < 4; i++) if (r[i]) return i;
        return -1;
    endfunction

    function automatic int ones(input logic [3:0] r);
        int n = 0;
        for (int i = 0; i < 4; i++) n += int'(r[i]);
        return n;
    endfunction

    task automatic model_reset();
        m_en = 0; m_conf = 0; m_tmo = 0; m_grant = 0; m_dout = 0; m_count = 0;
        m_guard = 0; m_drv = 0; m_eval_t = 0; m_off_t = -1; m_start_t = 0; m_idx = 0;
    endtask

    task automatic model_stop();
        m_drv = 0; m_en = 0; m_grant = 0; m_off_t = -1;
    endtask

    task automatic model_step(input logic neg, input logic pos, input logic rw,
                              input logic [3:0] req, input logic [31:0] data);
        m_conf = 0;
        if (neg) begin
            m_guard  = 1;
            m_eval_t = t + G;
            model_stop();
        end else if (m_guard) begin
            if (t == m_eval_t) begin
                m_guard = 0;
                if (rw && req != 0) begin
                    m_idx     = lowest(req);
                    m_drv     = 1;
                    m_en      = 1;
                    m_grant   = 4'(1 << m_idx);
                    m_dout    = data[8*m_idx +: 8];
                    m_start_t = t;
                    if (ones(req) >= 2) begin
                        m_conf = 1;
                        if (m_count != 16'hFFFF) m_count = m_count + 1;
                    end
                end
            end
        end else if (m_drv) begin
            if (m_off_t >= 0) begin
                if (t == m_off_t) model_stop();
            end else if (!rw) begin
                model_stop();
            end else if (pos) begin
                m_off_t = t + H;
                if (H == 0) model_stop();
`ifdef A2_DOUT_ARB_WATCHDOG_EN
            end else if (t == m_start_t + MAX) begin
                model_stop();
                m_tmo = 1;
`endif
            end else begin
                m_dout = data[8*m_idx +: 8];
            end
        end
    endtask

    task automatic compare_all();
        check("en",       data_out_en_o,    m_en);
        check("grant",    grant_o,          m_grant);
        check("dout",     data_out_o,       m_dout);
        check("conflict", conflict_o,       m_conf);
        check("count",    conflict_count_o, m_count);
        check("timeout",  timeout_o,        m_tmo);
    endtask

    // Called just after a falling clock edge; returns after the next one.
    task automatic tick(input logic neg, input logic pos);
        phi1_negedge = neg;
        phi1_posedge = pos;
        model_step(neg, pos, rw_n_i, req_i, data_i);
        t++;
        @(negedge clk_logic);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
    endtask

    initial begin
        system_reset_n = 1'b0;
        phi1_posedge = 0; phi1_negedge = 0; rw_n_i = 1; req_i = 0; data_i = 0;
        model_reset();
        @(negedge clk_logic);
        @(negedge clk_logic);
        compare_all();
        system_reset_n = 1'b1;

        // Single read, source 1 = A5
        req_i = 4'b0010; data_i = 32'h0000_A500;
        idle(9);
        tick(1, 0);
        tick(0, 0);
        check("tp_guard_en", data_out_en_o, 1'b0);
        tick(0, 0);
        check("tp_drive_en", data_out_en_o, 1'b1);
        check("tp_dout",     data_out_o,    8'hA5);
        check("tp_grant",    grant_o,       4'b0010);
        idle(26);
        tick(0, 1);
        check("tp_hold_en", data_out_en_o, 1'b1);
        tick(0, 0);
        check("tp_off_en", data_out_en_o, 1'b0);
        idle(3);

        // Conflict between sources 1 and 3
        req_i = 4'b1010; data_i = 32'h3C00_5A00;
        tick(1, 0); idle(2);
        check("cf_grant", grant_o,          4'b0010);
        check("cf_pulse", conflict_o,       1'b1);
        check("cf_count", conflict_count_o, 16'd1);
        tick(0, 0);
        check("cf_pulse_off", conflict_o, 1'b0);
        idle(4); tick(0, 1); idle(3);

        // Write cycle
        rw_n_i = 0; req_i = 4'b0001;
        tick(1, 0); idle(6);
        check("wr_en",    data_out_en_o,    1'b0);
        check("wr_count", conflict_count_o, 16'd1);
        tick(0, 1); idle(2);

        // R/W falls in DRIVE
        rw_n_i = 1; req_i = 4'b0100; data_i = 32'h0077_0000;
        tick(1, 0); idle(4);
        rw_n_i = 0;
        tick(0, 0);
        check("rwdrop_en", data_out_en_o, 1'b0);
        rw_n_i = 1;
        idle(3);

        // Short cycle: second phi0 rise 5 cycles into DRIVE
        req_i = 4'b0001; data_i = 32'h9900_0011;
        tick(1, 0); idle(7);
        req_i = 4'b1000;
        tick(1, 0);
        check("short_en",    data_out_en_o, 1'b0);
        check("short_grant", grant_o,       4'b0000);
        idle(2);
        check("short_regrant", grant_o,    4'b1000);
        check("short_dout",    data_out_o, 8'h99);
        idle(3); tick(0, 1); idle(3);

        // Bus clock stalls in DRIVE
        req_i = 4'b0010; data_i = 32'h0000_4200;
        tick(1, 0); idle(80);
`ifdef A2_DOUT_ARB_WATCHDOG_EN
        check("stall_en",  data_out_en_o, 1'b0);
        check("stall_tmo", timeout_o,     1'b1);
`else
        check("stall_en",  data_out_en_o, 1'b1);
`endif
        tick(0, 1); idle(3);

        // Randomized strobes, requests, data and R/W
        for (int i = 0; i < 3000; i++) begin
            rw_n_i = ($urandom_range(0, 7) != 0);
            req_i  = 4'($urandom);
            data_i = $urandom;
            tick(($urandom_range(0, 13) == 0), ($urandom_range(0, 9) == 0));
        end
        idle(4);

        // Asynchronous reset in DRIVE
        rw_n_i = 1; req_i = 4'b0100; data_i = 32'h00EE_0000;
        tick(1, 0); idle(5);
        check("pre_rst_en", data_out_en_o, 1'b1);
        #2 system_reset_n = 1'b0;
        #1;
        check("rst_en",    data_out_en_o,    1'b0);
        check("rst_grant", grant_o,          4'b0000);
        check("rst_dout",  data_out_o,       8'h00);
        check("rst_conf",  conflict_o,       1'b0);
        check("rst_count", conflict_count_o, 16'd0);
        check("rst_tmo",   timeout_o,        1'b0);
        model_reset();
        phi1_negedge = 0; phi1_posedge = 0;
        @(negedge clk_logic);
        t++;
        compare_all();
        system_reset_n = 1'b1;
        idle(2);

        // Saturation: preload near the top, then three conflicts
        force dut.r_conflict_count = 16'hFFFE;
        #1 release dut.r_conflict_count;
        m_count = 16'hFFFE;
        req_i = 4'b0111; data_i = 32'h0012_3456;
        for (int i = 0; i < 3; i++) begin
            tick(1, 0); idle(4); tick(0, 1); idle(2);
        end
        check("sat_count", conflict_count_o, 16'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
